// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller holds the master modport; the datapath (or a bench) holds the slave.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [4:0]       State;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_rd;
    logic             mem_wr;
    logic             iord;
    logic             alu_src_b;
    logic             reg_write;
    logic             wb_sel;
    logic             instr_done;
    logic             halted;
    logic             trap;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode,
        input  zero,
        input  mem_ready,
        output State,
        output pc_write,
        output pc_src,
        output ir_write,
        output mem_rd,
        output mem_wr,
        output iord,
        output alu_src_b,
        output reg_write,
        output wb_sel,
        output instr_done,
        output halted,
        output trap,
        output retired
    );

    modport slave (
        output opcode,
        output zero,
        output mem_ready,
        input  State,
        input  pc_write,
        input  pc_src,
        input  ir_write,
        input  mem_rd,
        input  mem_wr,
        input  iord,
        input  alu_src_b,
        input  reg_write,
        input  wb_sel,
        input  instr_done,
        input  halted,
        input  trap,
        input  retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Fetch/decode/execute/memory/write-back sequencer for the multi-cycle datapath,
// with Mealy fetch handshake and a saturating retired-instruction counter.
module multicycle_control #(
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.master ctrl
);

    typedef enum logic [4:0] {
        StIf     = 5'd0,
        StId     = 5'd1,
        StExR    = 5'd2,
        StExI    = 5'd3,
        StAddr   = 5'd4,
        StMemRd  = 5'd5,
        StMemWr  = 5'd6,
        StWbAlu  = 5'd7,
        StWbMem  = 5'd8,
        StBranch = 5'd9,
        StJump   = 5'd10,
        StHalt   = 5'd11,
        StTrap   = 5'd12
    } state_e;

    localparam logic [2:0] OpNop  = 3'd0;
    localparam logic [2:0] OpAluR = 3'd1;
    localparam logic [2:0] OpAluI = 3'd2;
    localparam logic [2:0] OpLw   = 3'd3;
    localparam logic [2:0] OpSw   = 3'd4;
    localparam logic [2:0] OpBeq  = 3'd5;
    localparam logic [2:0] OpJmp  = 3'd6;
    localparam logic [2:0] OpHalt = 3'd7;

    localparam logic [1:0] PcPlus1 = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJump = 2'd2;

    localparam logic [CNT_W-1:0] RetiredMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             illegal_op;
    logic [2:0]       op_class;

    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_rd;
    logic             mem_wr;
    logic             iord;
    logic             alu_src_b;
    logic             reg_write;
    logic             wb_sel;
    logic             instr_done;
    logic             halted;
    logic             trap;

    assign illegal_op = ctrl.opcode[3];
    assign op_class   = ctrl.opcode[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIf;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        pc_src     = PcPlus1;
        ir_write   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        alu_src_b  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;

        case (state_q)
            StIf: begin
                mem_rd = 1'b1;
                // Fetch completes in the ready cycle: latch IR and bump PC together.
                if (ctrl.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StId;
                end
            end
            StId: begin
                if (illegal_op) begin
                    state_d = StTrap;
                end else begin
                    case (op_class)
                        OpNop: begin
                            instr_done = 1'b1;
                            state_d    = StIf;
                        end
                        OpAluR:      state_d = StExR;
                        OpAluI:      state_d = StExI;
                        OpLw, OpSw:  state_d = StAddr;
                        OpBeq:       state_d = StBranch;
                        OpJmp:       state_d = StJump;
                        OpHalt: begin
                            instr_done = 1'b1;
                            state_d    = StHalt;
                        end
                        default:     state_d = StTrap;
                    endcase
                end
            end
            StExR: begin
                alu_src_b = 1'b0;
                state_d   = StWbAlu;
            end
            StExI: begin
                alu_src_b = 1'b1;
                state_d   = StWbAlu;
            end
            StAddr: begin
                alu_src_b = 1'b1;
                state_d   = (op_class == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (ctrl.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StIf;
                end
            end
            StWbAlu: begin
                reg_write  = 1'b1;
                wb_sel     = 1'b0;
                instr_done = 1'b1;
                state_d    = StIf;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                wb_sel     = 1'b1;
                instr_done = 1'b1;
                state_d    = StIf;
            end
            StBranch: begin
                pc_src     = PcBranch;
                pc_write   = ctrl.zero;
                instr_done = 1'b1;
                state_d    = StIf;
            end
            StJump: begin
                pc_src     = PcJump;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = StIf;
            end
            StHalt: begin
                halted  = 1'b1;
                state_d = StHalt;
            end
            StTrap: begin
                halted  = 1'b1;
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StIf;
        endcase
    end

    // Saturate rather than wrap so a long run never reports a small count.
    always_comb begin
        retired_d = retired_q;
        if (instr_done && (retired_q != RetiredMax)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign ctrl.State      = state_q;
    assign ctrl.pc_write   = pc_write;
    assign ctrl.pc_src     = pc_src;
    assign ctrl.ir_write   = ir_write;
    assign ctrl.mem_rd     = mem_rd;
    assign ctrl.mem_wr     = mem_wr;
    assign ctrl.iord       = iord;
    assign ctrl.alu_src_b  = alu_src_b;
    assign ctrl.reg_write  = reg_write;
    assign ctrl.wb_sel     = wb_sel;
    assign ctrl.instr_done = instr_done;
    assign ctrl.halted     = halted;
    assign ctrl.trap       = trap;
    assign ctrl.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, waits, reset, trap, saturation.
module tb_multicycle_control;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_control_if #(.CNT_W(16)) bus ();
    multicycle_control_if #(.CNT_W(2))  bus2 ();

    multicycle_control #(.CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    multicycle_control #(.CNT_W(2)) dut_sat (
        .clk  (clk),
        .rst  (rst2),
        .ctrl (bus2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   lw_st[10] = '{0, 0, 0, 1, 4, 5, 5, 5, 8, 0};
    logic lw_mr[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        bus.opcode     = 4'd0;
        bus.zero       = 1'b0;
        bus.mem_ready  = 1'b0;
        bus2.opcode    = 4'd0;
        bus2.zero      = 1'b0;
        bus2.mem_ready = 1'b1;

        // Reset held for 3 edges with no memory response
        repeat (3) tick();
        check_eq("rst_state", bus.State, 0);
        check_eq("rst_mem_rd", bus.mem_rd, 1);
        check_eq("rst_ir_write", bus.ir_write, 0);
        check_eq("rst_retired", bus.retired, 0);
        bus.mem_ready = 1'b1;
        tick();
        check_eq("rst_ready_ignored", bus.State, 0);
        rst = 1'b0;

        // ALU_R, no wait: 0,1,2,7,0
        bus.opcode = 4'd1;
        #1;
        check_eq("alur_if_state", bus.State, 0);
        check_eq("alur_if_ir_write", bus.ir_write, 1);
        check_eq("alur_if_pc_write", bus.pc_write, 1);
        check_eq("alur_if_pc_src", bus.pc_src, 0);
        tick();
        check_eq("alur_id_state", bus.State, 1);
        check_eq("alur_id_done", bus.instr_done, 0);
        tick();
        check_eq("alur_ex_state", bus.State, 2);
        check_eq("alur_ex_reg_write", bus.reg_write, 0);
        check_eq("alur_ex_alu_src_b", bus.alu_src_b, 0);
        tick();
        check_eq("alur_wb_state", bus.State, 7);
        check_eq("alur_wb_reg_write", bus.reg_write, 1);
        check_eq("alur_wb_sel", bus.wb_sel, 0);
        check_eq("alur_wb_done", bus.instr_done, 1);
        check_eq("alur_wb_retired", bus.retired, 0);
        tick();
        check_eq("alur_end_state", bus.State, 0);
        check_eq("alur_retired", bus.retired, 1);

        // LW with 2 wait cycles in IF and in MEM_RD
        bus.opcode = 4'd3;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = lw_mr[i];
            #1;
            check_eq($sformatf("lw_state_%0d", i), bus.State, lw_st[i]);
            check_eq($sformatf("lw_mem_rd_%0d", i), bus.mem_rd,
                     (lw_st[i] == 0 || lw_st[i] == 5) ? 1 : 0);
            if (lw_st[i] == 5) check_eq("lw_iord", bus.iord, 1);
            if (lw_st[i] == 8) check_eq("lw_wb_sel", bus.wb_sel, 1);
            if (i < 9) tick();
        end
        check_eq("lw_retired", bus.retired, 2);

        // SW with one wait in MEM_WR
        bus.opcode    = 4'd4;
        bus.mem_ready = 1'b1;
        #1;
        check_eq("sw_if_state", bus.State, 0);
        tick();
        check_eq("sw_id_state", bus.State, 1);
        tick();
        check_eq("sw_addr_state", bus.State, 4);
        check_eq("sw_addr_alu_src_b", bus.alu_src_b, 1);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check_eq("sw_wr_state", bus.State, 6);
        check_eq("sw_wr_mem_wr", bus.mem_wr, 1);
        check_eq("sw_wr_iord", bus.iord, 1);
        check_eq("sw_wr_wait_done", bus.instr_done, 0);
        tick();
        check_eq("sw_wr_hold", bus.State, 6);
        bus.mem_ready = 1'b1;
        #1;
        check_eq("sw_wr_done", bus.instr_done, 1);
        tick();
        check_eq("sw_end_state", bus.State, 0);
        check_eq("sw_retired", bus.retired, 3);

        // BEQ taken then not taken
        bus.opcode = 4'd5;
        bus.zero   = 1'b1;
        tick();
        tick();
        check_eq("beq1_state", bus.State, 9);
        check_eq("beq1_pc_write", bus.pc_write, 1);
        check_eq("beq1_pc_src", bus.pc_src, 1);
        check_eq("beq1_done", bus.instr_done, 1);
        tick();
        bus.zero = 1'b0;
        tick();
        tick();
        check_eq("beq0_state", bus.State, 9);
        check_eq("beq0_pc_write", bus.pc_write, 0);
        check_eq("beq0_pc_src", bus.pc_src, 1);
        tick();
        check_eq("beq_retired", bus.retired, 5);

        // JMP
        bus.opcode = 4'd6;
        tick();
        tick();
        check_eq("jmp_state", bus.State, 10);
        check_eq("jmp_pc_src", bus.pc_src, 2);
        check_eq("jmp_pc_write", bus.pc_write, 1);
        tick();
        check_eq("jmp_retired", bus.retired, 6);

        // NOP retires in ID
        bus.opcode = 4'd0;
        tick();
        check_eq("nop_id_done", bus.instr_done, 1);
        tick();
        check_eq("nop_end_state", bus.State, 0);
        check_eq("nop_retired", bus.retired, 7);

        // Asynchronous reset in the middle of MEM_RD
        bus.opcode = 4'd3;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check_eq("rdabort_pre_state", bus.State, 5);
        #2 rst = 1'b1;
        #1;
        check_eq("rdabort_state", bus.State, 0);
        check_eq("rdabort_retired", bus.retired, 0);
        check_eq("rdabort_mem_rd", bus.mem_rd, 1);
        tick();
        rst           = 1'b0;
        bus.mem_ready = 1'b1;

        // Asynchronous reset while a write is pending
        bus.opcode = 4'd4;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check_eq("wrabort_pre_mem_wr", bus.mem_wr, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("wrabort_mem_wr", bus.mem_wr, 0);
        check_eq("wrabort_state", bus.State, 0);
        tick();
        rst           = 1'b0;
        bus.mem_ready = 1'b1;

        // One NOP, then illegal opcode 12 traps with no retirement
        bus.opcode = 4'd0;
        tick();
        tick();
        check_eq("pretrap_retired", bus.retired, 1);
        bus.opcode = 4'd12;
        #1;
        check_eq("trap_if_state", bus.State, 0);
        tick();
        check_eq("trap_id_state", bus.State, 1);
        check_eq("trap_id_done", bus.instr_done, 0);
        tick();
        check_eq("trap_state", bus.State, 12);
        check_eq("trap_trap", bus.trap, 1);
        check_eq("trap_halted", bus.halted, 1);
        repeat (3) tick();
        check_eq("trap_hold", bus.State, 12);
        check_eq("trap_retired", bus.retired, 1);
        check_eq("trap_mem_rd", bus.mem_rd, 0);
        rst = 1'b1;
        #1;
        check_eq("trap_rst_state", bus.State, 0);
        tick();
        rst = 1'b0;

        // HALT retires in ID and then holds
        bus.opcode = 4'd7;
        tick();
        check_eq("halt_id_done", bus.instr_done, 1);
        tick();
        check_eq("halt_state", bus.State, 11);
        check_eq("halt_halted", bus.halted, 1);
        check_eq("halt_trap", bus.trap, 0);
        repeat (3) tick();
        check_eq("halt_hold", bus.State, 11);
        check_eq("halt_retired", bus.retired, 1);

        // Saturation with a 2-bit counter over 5 NOPs
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            check_eq($sformatf("sat_retired_%0d", i), bus2.retired, sat_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
